// File: rtl/cpu_cache_pkg.sv
// rtl/cpu_cache_pkg.sv - shared types and helpers for the cache fill arbiter
package cpu_cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    localparam logic CH_I = 1'b0;
    localparam logic CH_D = 1'b1;

    // Clear the in-block offset bits; 32-bit wide so any ADDR_W up to 32 fits.
    function automatic logic [31:0] blk_base(input logic [31:0] addr, input int off);
        return addr & ~((32'd1 << off) - 32'd1);
    endfunction

endpackage

// File: rtl/cache_fill_arbiter_if.sv
// rtl/cache_fill_arbiter_if.sv - request, main-memory and fill-port bundle
interface cache_fill_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [1:0]        req_valid;
    logic [ADDR_W-1:0] req_addr_i;
    logic [ADDR_W-1:0] req_addr_d;
    logic [1:0]        busy;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_data_valid;
    logic [DATA_W-1:0] mem_data;
    logic              fill_wen;
    logic              fill_sel;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;
    logic              tag_wen;

    modport master (
        input  req_valid, req_addr_i, req_addr_d, mem_data_valid, mem_data,
        output busy, mem_rd_en, mem_addr, fill_wen, fill_sel, fill_addr, fill_data, tag_wen
    );

    modport slave (
        output req_valid, req_addr_i, req_addr_d, mem_data_valid, mem_data,
        input  busy, mem_rd_en, mem_addr, fill_wen, fill_sel, fill_addr, fill_data, tag_wen
    );
endinterface

// File: rtl/fill_counter.sv
// rtl/fill_counter.sv - up-counter with clear, enable and terminal-count flag
module fill_counter #(
    parameter int WIDTH = 3,
    parameter int TC    = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o
);
    localparam logic [WIDTH-1:0] TC_V = WIDTH'(TC);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == TC_V);

endmodule

// File: rtl/cache_fill_arbiter.sv
// rtl/cache_fill_arbiter.sv - I/D miss arbiter streaming one block per fill
module cache_fill_arbiter
    import cpu_cache_pkg::*;
#(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4,
    parameter int D_PRIORITY      = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    cache_fill_arbiter_if.master arb
);
    localparam int CW  = $clog2(WORDS_PER_BLOCK);
    localparam int OFF = CW + 1;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] base_q, base_d;

    logic              in_fill, issuing, fill_wen_w, win;
    logic [CW:0]       issue_cnt;
    logic              issue_done;
    logic [CW-1:0]     rcv_cnt;
    logic              rcv_last;

    assign in_fill    = (state_q == FILL);
    assign issuing    = in_fill & ~issue_done;
    assign fill_wen_w = in_fill & arb.mem_data_valid;

    // Issue counter runs one past the last word so its terminal flag stops the read burst.
    fill_counter #(.WIDTH(CW + 1), .TC(WORDS_PER_BLOCK)) u_issue (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (~in_fill),
        .en_i  (issuing),
        .cnt_o (issue_cnt),
        .tc_o  (issue_done)
    );

    fill_counter #(.WIDTH(CW), .TC(WORDS_PER_BLOCK - 1)) u_rcv (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (~in_fill),
        .en_i  (fill_wen_w),
        .cnt_o (rcv_cnt),
        .tc_o  (rcv_last)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        base_d  = base_q;
        win     = (arb.req_valid[CH_D] && (D_PRIORITY != 0 || !arb.req_valid[CH_I])) ? CH_D : CH_I;
        case (state_q)
            IDLE: begin
                if (arb.req_valid != 2'b00) begin
                    owner_d = win;
                    base_d  = ADDR_W'(blk_base(32'(win ? arb.req_addr_d : arb.req_addr_i), OFF));
                    state_d = FILL;
                end
            end
            FILL: begin
                if (fill_wen_w && rcv_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            base_q  <= base_d;
        end
    end

    assign arb.mem_rd_en = issuing;
    assign arb.mem_addr  = issuing ? base_q + ADDR_W'({issue_cnt, 1'b0}) : '0;
    assign arb.fill_wen  = fill_wen_w;
    assign arb.fill_sel  = fill_wen_w & owner_q;
    assign arb.fill_addr = fill_wen_w ? base_q + ADDR_W'({rcv_cnt, 1'b0}) : '0;
    assign arb.fill_data = fill_wen_w ? arb.mem_data : '0;
    assign arb.tag_wen   = fill_wen_w & rcv_last;
    // Stall follows the raw miss immediately; the owner stays stalled until its tag lands.
    assign arb.busy      = arb.req_valid | (in_fill ? (owner_q ? 2'b10 : 2'b01) : 2'b00);

endmodule
